// File: rtl/bram_port_arbiter_if.sv
// Request/grant bundle between the NPU requesters and the BRAM read-port arbiter.
// The master side issues requests; the slave side drives grant, mux select and read strobes.
interface bram_port_arbiter_if;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       bram_en;
    logic [2:0] rvalid;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  bram_en,
        input  rvalid
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output bram_en,
        output rvalid
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among three requesters.
// Grants bursts of up to MAX_BURST beats with one mandatory idle cycle between grants.
module bram_port_arbiter #(
    parameter int BIT_DEPTH = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    if (BIT_DEPTH < 1) begin : g_bad_depth
        $error("BIT_DEPTH must be positive");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST must be within 1..255");
    end

    typedef enum logic {IDLE, BUSY} state_e;

    state_e         state_q, state_d;
    logic [1:0]     cur_q, cur_d;
    logic [1:0]     last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     gnt_q, gnt_d;
    logic [1:0]     sel_q, sel_d;
    logic           en_q, en_d;
    logic [2:0]     rvalid_q, rvalid_d;

    logic [1:0]     p0, p1, win;

    // Priority order after the last served requester: last+1, last+2, last.
    always_comb begin
        p0  = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        p1  = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
        win = last_q;
        if (bus.req[p0]) begin
            win = p0;
        end else if (bus.req[p1]) begin
            win = p1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = 3'b000;
        sel_d    = 2'b00;
        en_d     = 1'b0;
        rvalid_d = {3{en_q}} & gnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req != 3'b000) begin
                    state_d = BUSY;
                    cur_d   = win;
                    gnt_d   = 3'b001 << win;
                    sel_d   = win + 2'd1;
                    en_d    = 1'b1;
                    cnt_d   = CW'(1);
                end
            end
            BUSY: begin
                if (bus.req[cur_q] && cnt_q < CW'(MAX_BURST)) begin
                    gnt_d = gnt_q;
                    sel_d = sel_q;
                    en_d  = en_q;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    last_d  = cur_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= 2'd0;
            last_q   <= 2'd2;
            cnt_q    <= '0;
            gnt_q    <= 3'b000;
            sel_q    <= 2'b00;
            en_q     <= 1'b0;
            rvalid_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.bram_en = en_q;
    assign bus.rvalid  = rvalid_q;
endmodule
